// File: rtl/enc8_req_arb.sv
// Request encoder/arbiter: synchronizes eight active-low request lines, latches their
// assertions and presents one 4-bit code (A[3]=0 valid, 4'h8 none) until acknowledged.
module enc8_req_arb #(
  parameter int RR          = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       res_n,
  input  logic [7:0] req_n,
  input  logic       ack,
  input  logic       ovr_clr,
  output logic [3:0] A,
  output logic       valid,
  output logic [7:0] pend,
  output logic [7:0] ovr
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD} state_t;

  localparam logic [3:0] CODE_NONE = 4'h8;

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  s_d_q;
  logic [7:0]                  s;
  logic [7:0]                  rise;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic       valid_q, valid_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] ovr_q, ovr_d;
  logic       ack_acc;
  logic [7:0] clr;
  logic [2:0] win_idx;
  logic [2:0] idx;
  logic       win_found;

  // Synchronizer and edge-detect flops idle high (no request).
  always_ff @(posedge clk_in or negedge res_n) begin
    if (!res_n) begin
      sync_q <= '1;
      s_d_q  <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_n};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s_d_q & ~s;

  // Search from the pointer in round-robin mode, from line 0 otherwise.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    idx       = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = (RR != 0) ? ptr_q + 3'(k) : 3'(k);
      if (!win_found && pend_q[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    ack_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        a_d     = CODE_NONE;
        valid_d = 1'b0;
        if (win_found) begin
          state_d = S_GRANT;
          a_d     = {1'b0, win_idx};
          valid_d = 1'b1;
        end
      end
      S_GRANT: begin
        if (ack) begin
          ack_acc = 1'b1;
          state_d = S_HOLD;
          a_d     = CODE_NONE;
          valid_d = 1'b0;
          ptr_d   = a_q[2:0] + 3'd1;
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
        a_d     = CODE_NONE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        a_d     = CODE_NONE;
        valid_d = 1'b0;
      end
    endcase
  end

  // A new assertion on the same cycle as its acknowledge re-pends the line.
  assign clr    = ack_acc ? (8'd1 << a_q[2:0]) : 8'd0;
  assign pend_d = rise | (pend_q & ~clr);
  assign ovr_d  = (rise & pend_q & ~clr) | (ovr_q & ~{8{ovr_clr}});

  always_ff @(posedge clk_in or negedge res_n) begin
    if (!res_n) begin
      state_q <= S_IDLE;
      a_q     <= CODE_NONE;
      valid_q <= 1'b0;
      ptr_q   <= 3'd0;
      pend_q  <= 8'd0;
      ovr_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign A     = a_q;
  assign valid = valid_q;
  assign pend  = pend_q;
  assign ovr   = ovr_q;

endmodule
